// File: rtl/div_unit.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and W forms), restoring, one quotient bit per cycle.
// Latency N+1 cycles (N=64, or 32 for W), 1 for divide-by-zero/overflow; busy stalls EX, flush aborts, start taken only when ready.
module div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [1:0]      div_op,
   input  logic            is_word,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_n;
   logic            rem_sel_q, word_q, negq_q, negr_q;
   logic [XLEN-1:0] dvd_q, dsr_q, rem_q;
   logic [5:0]      cnt_q;

   logic            is_signed, neg_a, neg_b, div_zero, ovf, special;
   logic [XLEN-1:0] a_ext, b_ext, a_res, mag_a, mag_b, spec_res;

   // Operand preparation and special-case detection, evaluated while IDLE
   always_comb begin
      is_signed = ~div_op[0];
      a_res     = op1;
      a_ext     = op1;
      b_ext     = op2;
      if (is_word) begin
         a_res = {{(XLEN-32){op1[31]}}, op1[31:0]};
         a_ext = is_signed ? a_res : {{(XLEN-32){1'b0}}, op1[31:0]};
         b_ext = is_signed ? {{(XLEN-32){op2[31]}}, op2[31:0]}
                           : {{(XLEN-32){1'b0}}, op2[31:0]};
      end
      neg_a    = is_signed & a_ext[XLEN-1];
      neg_b    = is_signed & b_ext[XLEN-1];
      mag_a    = neg_a ? -a_ext : a_ext;
      mag_b    = neg_b ? -b_ext : b_ext;
      div_zero = (b_ext == '0);
      ovf      = is_signed && (&b_ext) &&
                 (is_word ? (a_ext == {{(XLEN-31){1'b1}}, {31{1'b0}}})
                          : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
      special  = div_zero | ovf;
      if (div_op[1]) spec_res = div_zero ? a_res : '0;
      else           spec_res = div_zero ? '1 : a_res;
   end

   logic [XLEN:0]   rem_sh;
   logic            qbit;
   logic [XLEN-1:0] trial, rem_n, quo_n, q_fix, r_fix, fin_raw, fin_res;

   // One restoring step; the dividend register doubles as the quotient shift register
   always_comb begin
      rem_sh  = {rem_q, dvd_q[XLEN-1]};
      trial   = rem_sh[XLEN-1:0] - dsr_q;
      qbit    = (rem_sh >= {1'b0, dsr_q});
      rem_n   = qbit ? trial : rem_sh[XLEN-1:0];
      quo_n   = {dvd_q[XLEN-2:0], qbit};
      q_fix   = negq_q ? -quo_n : quo_n;
      r_fix   = negr_q ? -rem_n : rem_n;
      fin_raw = rem_sel_q ? r_fix : q_fix;
      fin_res = word_q ? {{(XLEN-32){fin_raw[31]}}, fin_raw[31:0]} : fin_raw;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start && !flush) state_n = special ? DONE : CALC;
         CALC: begin
            if (flush)             state_n = IDLE;
            else if (cnt_q == '0)  state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         rem_sel_q <= 1'b0;
         word_q    <= 1'b0;
         negq_q    <= 1'b0;
         negr_q    <= 1'b0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         result    <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  rem_sel_q <= div_op[1];
                  word_q    <= is_word;
                  negq_q    <= neg_a ^ neg_b;
                  negr_q    <= neg_a;
                  dsr_q     <= mag_b;
                  rem_q     <= '0;
                  dvd_q     <= is_word ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                  cnt_q     <= is_word ? 6'd31 : 6'd63;
                  if (special) result <= spec_res;
               end
            end
            CALC: begin
               if (!flush) begin
                  rem_q <= rem_n;
                  dvd_q <= quo_n;
                  if (cnt_q != '0) cnt_q <= cnt_q - 6'd1;
                  else             result <= fin_res;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

   logic        clock = 1'b0;
   logic        reset, start, flush, is_word;
   logic        ready, busy, done;
   logic [63:0] op1, op2, result;
   logic [1:0]  div_op;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   always #5 clock = ~clock;

   div_unit #(.XLEN(64)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .op1    (op1),
      .op2    (op2),
      .div_op (div_op),
      .is_word(is_word),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Returns {special, result} computed with plain integer arithmetic
   function automatic logic [64:0] model(input logic [1:0] op, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      longint      sa, sb, minv;
      logic [63:0] ua, ub, q, r, res;
      bit          sp;
      sp = 0;
      if (!op[0]) begin
         sa   = w ? longint'($signed(a[31:0])) : $signed(a);
         sb   = w ? longint'($signed(b[31:0])) : $signed(b);
         minv = w ? longint'(32'sh8000_0000) : longint'(64'h8000_0000_0000_0000);
         if (sb == 0) begin
            q = '1; r = sa; sp = 1;
         end else if (sa == minv && sb == -1) begin
            q = sa; r = '0; sp = 1;
         end else begin
            q = sa / sb; r = sa % sb;
         end
      end else begin
         ua = w ? {32'b0, a[31:0]} : a;
         ub = w ? {32'b0, b[31:0]} : b;
         if (ub == 0) begin
            q = '1; r = ua; sp = 1;
         end else begin
            q = ua / ub; r = ua % ub;
         end
      end
      res = op[1] ? r : q;
      if (w) res = {{32{res[31]}}, res[31:0]};
      return {sp, res};
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge of cycle N+2 (ready again)
   task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
      logic [64:0] m;
      int          lat, cyc;
      bit          seen, stall_ok;
      m        = model(op, w, a, b);
      lat      = m[64] ? 1 : (w ? 33 : 65);
      chk({tag, " ready@0"}, 64'(ready), 64'd1);
      start    = 1'b1; op1 = a; op2 = b; div_op = op; is_word = w;
      seen     = 0; stall_ok = 1; cyc = 0;
      while (!seen && cyc < 200) begin
         @(negedge clock);
         cyc++;
         start   = 1'b0;
         op1     = {$urandom, $urandom};
         op2     = {$urandom, $urandom};
         div_op  = 2'($urandom);
         is_word = 1'($urandom);
         if (done) seen = 1;
         else if (ready || !busy) stall_ok = 0;
      end
      chk({tag, " done_cycle"}, 64'(cyc), 64'(lat));
      chk({tag, " stall"}, 64'(stall_ok), 64'd1);
      chk({tag, " rdy_busy@done"}, {62'd0, ready, busy}, 64'b01);
      chk({tag, " result"}, result, m[63:0]);
      @(negedge clock);
      chk({tag, " after"}, {61'd0, ready, busy, done}, 64'b100);
   endtask

   task automatic begin_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      start = 1'b1; op1 = a; op2 = b; div_op = op; is_word = 1'b0;
   endtask

   initial begin
      logic [63:0] prev, a, b;
      logic [1:0]  op;
      logic        w;
      bit          no_done;

      reset = 1'b1; start = 1'b0; flush = 1'b0; is_word = 1'b0;
      op1 = '0; op2 = '0; div_op = '0;
      repeat (3) @(negedge clock);
      chk("reset flags", {61'd0, ready, busy, done}, 64'b100);
      chk("reset result", result, 64'd0);
      reset = 1'b0;
      @(negedge clock);

      run_op("divu 100/7", DIVU, 1'b0, 64'd100, 64'd7);
      chk("divu const", result, 64'd14);
      run_op("remu 100/7", REMU, 1'b0, 64'd100, 64'd7);
      chk("remu const", result, 64'd2);
      run_op("rem -7/2", REM, 1'b0, -64'sd7, 64'd2);
      chk("rem const", result, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("div -7/2", DIV, 1'b0, -64'sd7, 64'd2);
      chk("div const", result, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div by0", DIV, 1'b0, 64'h1234, 64'd0);
      chk("div by0 const", result, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("remu by0", REMU, 1'b0, 64'h1234, 64'd0);
      chk("remu by0 const", result, 64'h1234);
      run_op("div ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("div ovf const", result, 64'h8000_0000_0000_0000);
      run_op("divw ovf", DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
      chk("divw ovf const", result, 64'hFFFF_FFFF_8000_0000);
      run_op("divuw", DIVU, 1'b1, 64'hDEAD_0000_FFFF_FFFE, 64'd1);
      chk("divuw const", result, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("remw -7/2", REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2);
      chk("remw const", result, 64'hFFFF_FFFF_FFFF_FFFF);

      // flush mid-calculation
      prev = result;
      begin_op(DIVU, 64'd1000, 64'd3);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      chk("flush idle@11", {61'd0, ready, busy, done}, 64'b100);
      no_done = 1;
      repeat (80) begin
         @(negedge clock);
         if (done) no_done = 0;
      end
      chk("flush no done", 64'(no_done), 64'd1);
      chk("flush result kept", result, prev);

      // flush in the last calculation cycle suppresses done
      begin_op(DIVU, 64'd77, 64'd7);
      for (int c = 1; c <= 64; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      chk("late flush", {61'd0, ready, busy, done}, 64'b100);
      chk("late flush result", result, prev);

      // flush together with start: start is dropped
      begin_op(DIVU, 64'd9, 64'd3);
      flush = 1'b1;
      @(negedge clock);
      start = 1'b0; flush = 1'b0;
      chk("start+flush", {61'd0, ready, busy, done}, 64'b100);

      // flush during DONE keeps that cycle's done
      begin_op(DIVU, 64'd50, 64'd5);
      for (int c = 1; c <= 65; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      chk("done before flush", 64'(done), 64'd1);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      chk("flush@done result", result, 64'd10);
      chk("flush@done idle", {61'd0, ready, busy, done}, 64'b100);

      // reset mid-operation
      begin_op(DIVU, 64'd12345, 64'd11);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid reset flags", {61'd0, ready, busy, done}, 64'b100);
      chk("mid reset result", result, 64'd0);
      no_done = 1;
      repeat (40) begin
         @(negedge clock);
         if (done) no_done = 0;
      end
      chk("mid reset no done", 64'(no_done), 64'd1);

      // randomized back-to-back operations
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         w  = 1'($urandom);
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            1: b = 64'($urandom_range(1, 20));
            2: b = '0;
            3: begin
               b = '1;
               a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            end
            4: a = 64'($urandom_range(0, 100));
            5: b = {32'd0, 32'($urandom_range(1, 1000))} | (b & 64'hFFFF_FFFF_0000_0000);
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), op, w, a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
